// File: rtl/i2c_master_write.sv
// Write-only I2C master: START, three MSB-first bytes each followed by an ACK clock, STOP.
// One frame per accepted start; a NACK aborts the remaining bytes and raises ack_err.
module i2c_master_write #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] data,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        i2c_sclk,
    inout  wire         i2c_sdat
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [15:0] LAST_Q = 16'(CLK_DIV - 1);

    state_t      state_q;
    logic [15:0] quarter_q;
    logic [15:0] quarter_d;
    logic [1:0]  phase_q;
    logic [2:0]  bit_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] shift_q;
    logic        scl_q;
    logic        sda_low_q;
    logic        busy_q;
    logic        done_q;
    logic        ack_err_q;
    logic        nack_q;
    logic        tick;

    // Quarter-period timebase; parked at zero whenever no frame is on the bus.
    always_comb begin
        tick      = (quarter_q == LAST_Q);
        quarter_d = tick ? 16'd0 : quarter_q + 16'd1;
        if (state_q == S_IDLE || state_q == S_DONE) begin
            quarter_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            quarter_q  <= 16'd0;
            phase_q    <= 2'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            quarter_q <= quarter_d;
            done_q    <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    scl_q     <= 1'b1;
                    sda_low_q <= 1'b0;
                    phase_q   <= 2'd0;
                    // busy_q is still high in the cycle after DONE, which masks start there.
                    busy_q    <= 1'b0;
                    if (start && !busy_q) begin
                        shift_q    <= data;
                        ack_err_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        byte_cnt_q <= 2'd0;
                        bit_cnt_q  <= 3'd7;
                        sda_low_q  <= 1'b1;
                        state_q    <= S_START;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (phase_q == 2'd0) begin
                            phase_q <= 2'd1;
                            scl_q   <= 1'b0;
                        end else begin
                            phase_q   <= 2'd0;
                            sda_low_q <= ~shift_q[23];
                            state_q   <= S_BIT;
                        end
                    end
                end

                S_BIT: begin
                    if (tick) begin
                        phase_q <= phase_q + 2'd1;
                        case (phase_q)
                            2'd0: scl_q <= 1'b1;
                            2'd2: scl_q <= 1'b0;
                            2'd3: begin
                                shift_q <= {shift_q[22:0], 1'b0};
                                if (bit_cnt_q != 3'd0) begin
                                    bit_cnt_q <= bit_cnt_q - 3'd1;
                                    sda_low_q <= ~shift_q[22];
                                end else begin
                                    sda_low_q <= 1'b0;
                                    state_q   <= S_ACK;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_ACK: begin
                    if (phase_q == 2'd2 && quarter_q == 16'd0) begin
                        nack_q <= i2c_sdat;
                    end
                    if (tick) begin
                        phase_q <= phase_q + 2'd1;
                        case (phase_q)
                            2'd0: scl_q <= 1'b1;
                            2'd2: scl_q <= 1'b0;
                            2'd3: begin
                                if (nack_q || byte_cnt_q == 2'd2) begin
                                    if (nack_q) begin
                                        ack_err_q <= 1'b1;
                                    end
                                    sda_low_q <= 1'b1;
                                    state_q   <= S_STOP;
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + 2'd1;
                                    bit_cnt_q  <= 3'd7;
                                    sda_low_q  <= ~shift_q[23];
                                    state_q    <= S_BIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        phase_q <= phase_q + 2'd1;
                        case (phase_q)
                            2'd0: scl_q <= 1'b1;
                            2'd1: sda_low_q <= 1'b0;
                            default: begin
                                phase_q <= 2'd0;
                                state_q <= S_DONE;
                            end
                        endcase
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ack_err  = ack_err_q;
    assign i2c_sclk = scl_q;
    assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_write.sv
`timescale 1ns/1ps
// Bench for i2c_master_write: a slave model decodes the bus and checks its timing;
// a scoreboard compares every finished frame against expectations queued at start.
module tb_i2c_master_write;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start;
    logic        sel;
    logic [23:0] data;
    logic        slave_pull = 1'b0;
    int          nack_byte  = 3;
    int          cyc        = 0;
    int          n_chk      = 0;
    int          n_err      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Two instances share the bench; sel picks which one is stimulated and observed.
    wire  sda4;
    wire  sda2;
    pullup (sda4);
    pullup (sda2);
    logic busy4, done4, err4, scl4;
    logic busy2, done2, err2, scl2;
    logic start4, start2;
    assign start4 = start && !sel;
    assign start2 = start && sel;
    assign sda4   = (slave_pull && !sel) ? 1'b0 : 1'bz;
    assign sda2   = (slave_pull && sel) ? 1'b0 : 1'bz;

    i2c_master_write #(.CLK_DIV(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .data(data),
        .busy(busy4), .done(done4), .ack_err(err4),
        .i2c_sclk(scl4), .i2c_sdat(sda4)
    );

    i2c_master_write #(.CLK_DIV(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .data(data),
        .busy(busy2), .done(done2), .ack_err(err2),
        .i2c_sclk(scl2), .i2c_sdat(sda2)
    );

    logic busy, done, ack_err, scl, sda;
    int   cdiv;
    assign busy    = sel ? busy2 : busy4;
    assign done    = sel ? done2 : done4;
    assign ack_err = sel ? err2  : err4;
    assign scl     = sel ? scl2  : scl4;
    assign sda     = sel ? sda2  : sda4;
    assign cdiv    = sel ? 2 : 4;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Slave model and bus-protocol checker.
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic       in_frame = 1'b0, stop_seen = 1'b0;
    logic       hi_chk = 1'b0, lo_chk = 1'b0;
    int         hi_len = 0, lo_len = 0, bitcnt = 0, pulses = 0;
    logic [7:0] cur = 8'd0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            in_frame   = 1'b0;
            slave_pull = 1'b0;
            hi_chk     = 1'b0;
            lo_chk     = 1'b0;
            bitcnt     = 0;
        end else begin
            if (scl == prev_scl) begin
                if (scl) hi_len++;
                else     lo_len++;
            end
            if (prev_scl && scl && (prev_sda != sda)) begin
                if (!sda) begin
                    chk("sda_fall_while_scl_high_in_frame", int'(in_frame), 0);
                    in_frame  = 1'b1;
                    stop_seen = 1'b0;
                    rx_q.delete();
                    bitcnt    = 0;
                    pulses    = 0;
                end else begin
                    chk("sda_rise_while_scl_high_outside_frame", int'(in_frame), 1);
                    stop_seen = in_frame;
                    in_frame  = 1'b0;
                    hi_chk    = 1'b0;
                end
            end
            if (!prev_scl && scl) begin
                if (lo_chk) chk("scl_low_width", lo_len, 2 * cdiv);
                hi_len = 1;
                hi_chk = in_frame;
                lo_chk = 1'b0;
                if (in_frame) begin
                    pulses++;
                    if (bitcnt < 8) begin
                        cur = {cur[6:0], sda};
                        bitcnt++;
                        if (bitcnt == 8) rx_q.push_back(cur);
                    end else begin
                        bitcnt = 9;
                    end
                end
            end else if (prev_scl && !scl) begin
                if (hi_chk) chk("scl_high_width", hi_len, 2 * cdiv);
                lo_len = 1;
                lo_chk = in_frame;
                hi_chk = 1'b0;
                if (in_frame && bitcnt == 8) begin
                    slave_pull = ((rx_q.size() - 1) != nack_byte);
                end else if (in_frame && bitcnt == 9) begin
                    slave_pull = 1'b0;
                    bitcnt     = 0;
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    // Scoreboard: one expectation per accepted start, consumed on each done pulse.
    typedef struct {
        logic [23:0] d;
        int          nack;
        int          t0;
        int          cd;
    } exp_t;
    exp_t exp_q[$];
    logic prev_done = 1'b0;

    always @(negedge clk) begin : sb_blk
        exp_t        e;
        int          nb;
        logic [23:0] dd;
        if (prev_done) begin
            chk("done_one_clk", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
        end
        prev_done = reset_n && done;
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e  = exp_q.pop_front();
                nb = (e.nack < 3) ? e.nack + 1 : 3;
                chk("done_latency", cyc - e.t0, (2 + 36 * nb + 3) * e.cd + 1);
                chk("ack_err", int'(ack_err), int'(e.nack < 3));
                chk("busy_in_done", int'(busy), 1);
                chk("stop_seen", int'(stop_seen), 1);
                // Every byte slot has 9 SCL rises, plus the rise that sets up STOP.
                chk("scl_pulses", pulses, 9 * nb + 1);
                chk("byte_count", rx_q.size(), nb);
                dd = e.d;
                for (int k = 0; k < nb && k < rx_q.size(); k++) begin
                    chk("rx_byte", int'(rx_q[k]), int'(dd[23:16]));
                    dd = dd << 8;
                end
                $display("frame data=%06h clk_div=%0d bytes=%0d ack_err=%0d latency=%0d",
                         e.d, e.cd, rx_q.size(), ack_err, cyc - e.t0);
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (busy) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic send(input logic [23:0] pay, input int nk);
        wait_idle();
        nack_byte = nk;
        start     = 1'b1;
        data      = pay;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_on_accept", int'(busy), 1);
        chk("ack_err_cleared_on_accept", int'(ack_err), 0);
        exp_q.push_back('{d: pay, nack: nk, t0: cyc, cd: cdiv});
    endtask

    initial begin
        int g;
        reset_n = 1'b1;
        start   = 1'b0;
        sel     = 1'b0;
        data    = 24'd0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_scl", int'(scl), 1);
        chk("reset_sda_released", int'(sda), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ack_err", int'(ack_err), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fully acknowledged frame, then NACK on the second byte.
        send(24'h341E00, 3);
        wait_idle();
        @(negedge clk);
        chk("ack_err_after_good_frame", int'(ack_err), 0);
        send(24'h340C5A, 1);
        wait_idle();
        @(negedge clk);
        chk("ack_err_after_nack", int'(ack_err), 1);

        // Random payloads through the protocol checker.
        for (int i = 0; i < 3; i++) send(24'($urandom), 3);

        // Starts while busy and in the done cycle are dropped.
        send(24'hA55A3C, 2);
        repeat (100) @(negedge clk);
        start = 1'b1;
        data  = 24'hFFFFFF;
        @(negedge clk);
        start = 1'b0;
        chk("busy_mid_frame", int'(busy), 1);
        g = 0;
        while (!done && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", int'(done), 1);
        start = 1'b1;
        data  = 24'hFFFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_in_done_cycle_ignored", int'(busy), 0);
        repeat (40) @(negedge clk);
        chk("no_queued_frame", int'(busy), 0);
        send(24'h5AC381, 3);

        // Reset during bit 3 of byte 1 (a 0 bit, so SDA is being driven low).
        wait_idle();
        nack_byte = 3;
        data      = 24'h34F00F;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (54 * 4 + 6) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_scl", int'(scl), 1);
        chk("midreset_sda_released", int'(sda), 1);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        send(24'h34F00F, 3);

        // Minimum divider, back-to-back frames.
        wait_idle();
        @(negedge clk);
        sel = 1'b1;
        @(negedge clk);
        send(24'h123456, 3);
        send(24'hC0FFEE, 3);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
